// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes and FSM states.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        WAIT_R = 2'b10,
        RESP   = 2'b11
    } state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane logic for the load/store unit: request-side byte enables, store data
// replication and misalignment check, plus response-side load extraction/extension.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [1:0]       size,
    input  logic [1:0]       offset,
    input  logic [width-1:0] wdata,
    output logic [3:0]       be,
    output logic [width-1:0] wdata_rep,
    output logic             misaligned,
    input  logic [1:0]       ld_size,
    input  logic [1:0]       ld_offset,
    input  logic             ld_signed,
    input  logic [width-1:0] rdata,
    output logic [width-1:0] rdata_ext
);

    logic [width-1:0] shifted;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = offset[0];
            end
            default: misaligned = (offset != 2'b00);  // size 11 behaves as a word
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_offset, 3'b000};
        case (ld_size)
            SZ_B:    rdata_ext = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_ext = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit top: accepts one datapath access, runs the req/gnt/rvalid
// handshake to word-addressed memory and returns an aligned response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int width  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [width-1:0]  req_addr,
    input  logic [width-1:0]  req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [width-1:0]  rsp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [width-1:0]  mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [width-1:0]  mem_rdata
);

    state_t           state;
    logic [1:0]       ld_size;
    logic [1:0]       ld_offset;
    logic             ld_signed;
    logic [3:0]       be_next;
    logic [width-1:0] wdata_next;
    logic [width-1:0] rdata_ext;
    logic             misaligned;

    lsu_align #(.width(width)) u_align (
        .size      (req_size),
        .offset    (req_addr[1:0]),
        .wdata     (req_wdata),
        .be        (be_next),
        .wdata_rep (wdata_next),
        .misaligned(misaligned),
        .ld_size   (ld_size),
        .ld_offset (ld_offset),
        .ld_signed (ld_signed),
        .rdata     (mem_rdata),
        .rdata_ext (rdata_ext)
    );

    // Combinational so the core freezes in the very cycle it presents a request.
    assign stall = rst_n &
                   (((state == IDLE) & req_valid) | (state == ISSUE) | (state == WAIT_R));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            ld_size   <= SZ_B;
            ld_offset <= 2'b00;
            ld_signed <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_rdata <= '0;
                        if (misaligned) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rsp_err   <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= be_next;
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_wdata <= wdata_next;
                            ld_size   <= req_size;
                            ld_offset <= req_addr[1:0];
                            ld_signed <= req_signed;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        rsp_rdata <= rdata_ext;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
